// File: rtl/asi_pkg.sv
// Shared AXI4 widths and encodings used by the slave (asi) and master (ami) interfaces.
// Also holds the master-side FSM state type and the burst/response encodings.
package asi_pkg;

  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_DW     = 32;
  localparam int AXI_WSTRBW = AXI_DW / 8;
  localparam int AXI_BRESPW = 2;
  localparam int AXI_RRESPW = 2;

  localparam logic [AXI_BURSTW-1:0] INCR   = 2'b01;
  localparam logic [AXI_BRESPW-1:0] OKAY   = 2'b00;
  localparam logic [AXI_BRESPW-1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_REJ
  } TYPE_AMI;

endpackage

// File: rtl/ami.sv
// AXI4 master interface: turns one user command at a time into a single INCR burst,
// streaming write beats in and read beats out, with a one-cycle completion strobe.
module ami
  import asi_pkg::*;
#(
  parameter logic [AXI_IW-1:0] MST_ID = '0
) (
  input  logic                  aclk_i,
  input  logic                  areset_i,
  // user command
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [AXI_AW-1:0]     cmd_addr_i,
  input  logic [AXI_LW-1:0]     cmd_len_i,
  input  logic [AXI_SW-1:0]     cmd_size_i,
  // user write stream
  input  logic [AXI_DW-1:0]     u_wdata_i,
  input  logic [AXI_WSTRBW-1:0] u_wstrb_i,
  input  logic                  u_wvalid_i,
  output logic                  u_wready_o,
  // user read stream
  output logic [AXI_DW-1:0]     u_rdata_o,
  output logic                  u_rlast_o,
  output logic                  u_rvalid_o,
  input  logic                  u_rready_i,
  // completion
  output logic                  done_valid_o,
  output logic                  done_write_o,
  output logic [1:0]            done_resp_o,
  output logic                  err_sticky_o,
  // AW
  output logic [AXI_IW-1:0]     awid_o,
  output logic [AXI_AW-1:0]     awaddr_o,
  output logic [AXI_LW-1:0]     awlen_o,
  output logic [AXI_SW-1:0]     awsize_o,
  output logic [AXI_BURSTW-1:0] awburst_o,
  output logic                  awlock_o,
  output logic [3:0]            awcache_o,
  output logic [2:0]            awprot_o,
  output logic [3:0]            awqos_o,
  output logic [3:0]            awregion_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  // W
  output logic [AXI_DW-1:0]     wdata_o,
  output logic [AXI_WSTRBW-1:0] wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  // B
  input  logic [AXI_IW-1:0]     bid_i,
  input  logic [AXI_BRESPW-1:0] bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  // AR
  output logic [AXI_IW-1:0]     arid_o,
  output logic [AXI_AW-1:0]     araddr_o,
  output logic [AXI_LW-1:0]     arlen_o,
  output logic [AXI_SW-1:0]     arsize_o,
  output logic [AXI_BURSTW-1:0] arburst_o,
  output logic                  arlock_o,
  output logic [3:0]            arcache_o,
  output logic [2:0]            arprot_o,
  output logic [3:0]            arqos_o,
  output logic [3:0]            arregion_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  // R
  input  logic [AXI_IW-1:0]     rid_i,
  input  logic [AXI_DW-1:0]     rdata_i,
  input  logic [AXI_RRESPW-1:0] rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam int MAX_SIZE = $clog2(AXI_DW / 8);
  localparam int XW       = 13 + AXI_LW;

  TYPE_AMI             state_q, state_d;
  logic [AXI_AW-1:0]   addr_q, addr_d;
  logic [AXI_LW-1:0]   len_q, len_d;
  logic [AXI_SW-1:0]   size_q, size_d;
  logic                write_q, write_d;
  logic [AXI_LW-1:0]   cnt_q, cnt_d;
  logic                rerr_q, rerr_d;
  logic                done_valid_q, done_valid_d;
  logic                done_write_q, done_write_d;
  logic [1:0]          done_resp_q, done_resp_d;
  logic                err_q, err_d;

  logic                in_w, in_r, w_hs, r_hs, last_beat, r_bad, illegal;
  logic [XW-1:0]       span_end;
  logic                unused_resp;

  // End of the burst relative to the 4 KB page; wide enough that it never wraps.
  assign span_end = XW'(cmd_addr_i[11:0]) + ((XW'(cmd_len_i) + XW'(1)) << cmd_size_i);
  assign illegal  = (cmd_size_i > AXI_SW'(MAX_SIZE)) || (span_end > XW'(4096));

  assign in_w      = (state_q == S_W);
  assign in_r      = (state_q == S_R);
  assign last_beat = (cnt_q == len_q);
  assign w_hs      = in_w & u_wvalid_i & wready_i;
  assign r_hs      = in_r & rvalid_i & u_rready_i;
  assign r_bad     = rresp_i[1] | (rid_i != MST_ID) | (rlast_i != last_beat);
  assign unused_resp = ^{bresp_i[0], rresp_i[0]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    rerr_d       = rerr_q;
    done_valid_d = 1'b0;
    done_write_d = done_write_q;
    done_resp_d  = done_resp_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          size_d  = cmd_size_i;
          write_d = cmd_write_i;
          cnt_d   = '0;
          rerr_d  = 1'b0;
          if (illegal) begin
            state_d      = S_REJ;
            done_valid_d = 1'b1;
            done_write_d = cmd_write_i;
            done_resp_d  = SLVERR;
            err_d        = 1'b1;
          end else begin
            state_d = cmd_write_i ? S_AW : S_AR;
          end
        end
      end
      S_REJ: state_d = S_IDLE;
      S_AW: if (awready_i) state_d = S_W;
      S_W: begin
        if (w_hs) begin
          if (last_beat) begin
            state_d = S_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AXI_LW'(1);
          end
        end
      end
      S_B: begin
        if (bvalid_i) begin
          state_d      = S_IDLE;
          done_valid_d = 1'b1;
          done_write_d = 1'b1;
          done_resp_d  = (bresp_i[1] || (bid_i != MST_ID)) ? SLVERR : OKAY;
          if (done_resp_d == SLVERR) err_d = 1'b1;
        end
      end
      S_AR: if (arready_i) state_d = S_R;
      S_R: begin
        // An early RLAST ends the burst as well as a full-length one.
        if (r_hs) begin
          if (rlast_i || last_beat) begin
            state_d      = S_IDLE;
            done_valid_d = 1'b1;
            done_write_d = 1'b0;
            done_resp_d  = (rerr_q || r_bad) ? SLVERR : OKAY;
          end else begin
            cnt_d  = cnt_q + AXI_LW'(1);
            rerr_d = rerr_q | r_bad;
          end
          if (r_bad) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      rerr_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_write_q <= 1'b0;
      done_resp_q  <= OKAY;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      rerr_q       <= rerr_d;
      done_valid_q <= done_valid_d;
      done_write_q <= done_write_d;
      done_resp_q  <= done_resp_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign done_valid_o = done_valid_q;
  assign done_write_o = done_write_q;
  assign done_resp_o  = done_resp_q;
  assign err_sticky_o = err_q;

  assign awid_o     = MST_ID;
  assign awaddr_o   = addr_q;
  assign awlen_o    = len_q;
  assign awsize_o   = size_q;
  assign awburst_o  = INCR;
  assign awlock_o   = 1'b0;
  assign awcache_o  = 4'b0011;
  assign awprot_o   = '0;
  assign awqos_o    = '0;
  assign awregion_o = '0;
  assign awvalid_o  = (state_q == S_AW);

  assign wdata_o    = in_w ? u_wdata_i : '0;
  assign wstrb_o    = in_w ? u_wstrb_i : '0;
  assign wlast_o    = in_w & last_beat;
  assign wvalid_o   = in_w & u_wvalid_i;
  assign u_wready_o = in_w & wready_i;

  assign bready_o   = (state_q == S_B);

  assign arid_o     = MST_ID;
  assign araddr_o   = addr_q;
  assign arlen_o    = len_q;
  assign arsize_o   = size_q;
  assign arburst_o  = INCR;
  assign arlock_o   = 1'b0;
  assign arcache_o  = 4'b0011;
  assign arprot_o   = '0;
  assign arqos_o    = '0;
  assign arregion_o = '0;
  assign arvalid_o  = (state_q == S_AR);

  assign u_rdata_o  = rdata_i;
  assign u_rlast_o  = in_r & rlast_i;
  assign u_rvalid_o = in_r & rvalid_i;
  assign rready_o   = in_r & u_rready_i;

endmodule

// File: tb/tb_ami.sv
// Self-checking bench for ami: a transaction-level AXI slave and user model drive
// directed and random commands; expectations come from the command rules alone.
`timescale 1ns/1ps
module tb_ami;
  import asi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_ready, cmd_write;
  logic [AXI_AW-1:0] cmd_addr;
  logic [AXI_LW-1:0] cmd_len;
  logic [AXI_SW-1:0] cmd_size;
  logic [AXI_DW-1:0] u_wdata, u_rdata, wdata, rdata;
  logic [AXI_WSTRBW-1:0] u_wstrb, wstrb;
  logic u_wvalid, u_wready, u_rlast, u_rvalid, u_rready;
  logic done_valid, done_write, err_sticky;
  logic [1:0] done_resp;
  logic [AXI_IW-1:0] awid, arid, bid, rid;
  logic [AXI_AW-1:0] awaddr, araddr;
  logic [AXI_LW-1:0] awlen, arlen;
  logic [AXI_SW-1:0] awsize, arsize;
  logic [AXI_BURSTW-1:0] awburst, arburst;
  logic awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion;
  logic [2:0] awprot, arprot;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic [1:0] bresp, rresp;

  ami #(.MST_ID('0)) dut (
    .aclk_i(clk), .areset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
    .u_wdata_i(u_wdata), .u_wstrb_i(u_wstrb), .u_wvalid_i(u_wvalid), .u_wready_o(u_wready),
    .u_rdata_o(u_rdata), .u_rlast_o(u_rlast), .u_rvalid_o(u_rvalid), .u_rready_i(u_rready),
    .done_valid_o(done_valid), .done_write_o(done_write), .done_resp_o(done_resp),
    .err_sticky_o(err_sticky),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot), .awqos_o(awqos),
    .awregion_o(awregion), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot), .arqos_o(arqos),
    .arregion_o(arregion), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_o(rready)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rresp = 0; rlast = 0; rid = 0; rdata = 0;
    u_wvalid = 0; u_wdata = 0; u_wstrb = 0; u_rready = 0;
  endtask

  // Called at a negedge+1 point; returns in the cycle after the handshake.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    set_idle();
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
    #1 chk("cmd_ready_before", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    $display("cmd wr=%0d addr=%08h len=%0d size=%0d", wr, a, l, s);
  endtask

  task automatic run_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input int aw_delay, input bit bp, input logic [1:0] br,
                           input bit bid_bad, input int rst_beat);
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    int beat = 0, ph = 0, waitc = 0, n = 0;
    bit fin = 0;
    logic [1:0] exp_resp;
    for (int i = 0; i <= int'(l); i++) begin
      wd.push_back($urandom);
      ws.push_back(4'($urandom));
    end
    exp_resp = (br[1] || bid_bad) ? 2'b10 : 2'b00;
    issue(1, a, l, s);
    while (!fin && n < 400) begin
      if (ph == 3) begin
        set_idle();
        #1;
        if (exp_resp == 2'b10) exp_err = 1'b1;
        chk("wr_done_valid", done_valid, 1);
        chk("wr_done_write", done_write, 1);
        chk("wr_done_resp", done_resp, exp_resp);
        chk("wr_err_sticky", err_sticky, exp_err);
        chk("wr_cmd_ready_done", cmd_ready, 1);
        $display("write done addr=%08h beats=%0d resp=%0d", a, beat, done_resp);
        fin = 1;
      end else begin
        awready  = (ph == 0) && (waitc >= aw_delay);
        wready   = (ph == 0) || ((ph == 1) && (!bp || $urandom_range(3) != 0));
        u_wvalid = (ph == 0) || ((ph == 1) && (!bp || $urandom_range(3) != 0));
        u_wdata  = (beat <= int'(l)) ? wd[beat] : '0;
        u_wstrb  = (beat <= int'(l)) ? ws[beat] : '0;
        bvalid   = (ph == 2);
        bresp    = br;
        bid      = bid_bad ? 4'h5 : 4'h0;
        if (ph == 1 && beat == rst_beat) begin
          wready = 1; u_wvalid = 1;
        end
        #1;
        chk("wr_done_low", done_valid, 0);
        case (ph)
          0: begin
            chk("awvalid", awvalid, 1);
            chk("awaddr", awaddr, a);
            chk("awlen", awlen, l);
            chk("awsize", awsize, s);
            chk("awburst", awburst, 2'b01);
            chk("awcache", awcache, 4'b0011);
            chk("wvalid_in_aw", wvalid, 0);
            chk("u_wready_in_aw", u_wready, 0);
            if (awready) ph = 1; else waitc++;
          end
          1: begin
            chk("awvalid_after_hs", awvalid, 0);
            chk("wvalid_pass", wvalid, u_wvalid);
            chk("u_wready_pass", u_wready, wready);
            if (beat == rst_beat) begin
              rst = 1;
              #1;
              chk("rst_awvalid", awvalid, 0);
              chk("rst_wvalid", wvalid, 0);
              chk("rst_u_wready", u_wready, 0);
              chk("rst_bready", bready, 0);
              chk("rst_arvalid", arvalid, 0);
              @(negedge clk);
              rst = 0;
              set_idle();
              #1;
              exp_err = 1'b0;
              chk("rst_cmd_ready", cmd_ready, 1);
              chk("rst_err_sticky", err_sticky, 0);
              $display("reset during write beat %0d", beat + 1);
              return;
            end
            if (u_wvalid && wready) begin
              chk("wdata", wdata, wd[beat]);
              chk("wstrb", wstrb, ws[beat]);
              chk("wlast", wlast, beat == int'(l));
              if (beat == int'(l)) ph = 2;
              beat++;
            end
          end
          default: begin
            chk("bready", bready, 1);
            chk("wvalid_in_b", wvalid, 0);
            ph = 3;
          end
        endcase
        @(negedge clk);
        n++;
      end
    end
    if (!fin) chk("wr_timeout", 0, 1);
  endtask

  task automatic run_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input bit throttle, input int err_beat, input int last_beat,
                          input int rid_bad_beat);
    int beat = 0, ph = 0, n = 0;
    bit fin = 0, bad = 0;
    logic [31:0] rd;
    issue(0, a, l, s);
    while (!fin && n < 600) begin
      if (ph == 2) begin
        set_idle();
        #1;
        if (bad) exp_err = 1'b1;
        chk("rd_done_valid", done_valid, 1);
        chk("rd_done_write", done_write, 0);
        chk("rd_done_resp", done_resp, bad ? 2'b10 : 2'b00);
        chk("rd_err_sticky", err_sticky, exp_err);
        chk("rd_cmd_ready_done", cmd_ready, 1);
        $display("read done addr=%08h beats=%0d resp=%0d", a, beat, done_resp);
        fin = 1;
      end else begin
        arready  = (ph == 0) && ($urandom_range(1) == 0);
        rvalid   = (ph == 1) && ($urandom_range(4) != 0);
        rd       = $urandom;
        rdata    = rd;
        rresp    = (beat == err_beat) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
        rlast    = (beat == last_beat);
        rid      = (beat == rid_bad_beat) ? 4'h3 : 4'h0;
        u_rready = throttle ? (n % 3 == 0) : 1'b1;
        #1;
        chk("rd_done_low", done_valid, 0);
        if (ph == 0) begin
          chk("arvalid", arvalid, 1);
          chk("araddr", araddr, a);
          chk("arlen", arlen, l);
          chk("arsize", arsize, s);
          chk("arburst", arburst, 2'b01);
          chk("arcache", arcache, 4'b0011);
          chk("rready_in_ar", rready, 0);
          if (arready) ph = 1;
        end else begin
          chk("arvalid_after_hs", arvalid, 0);
          chk("rready_pass", rready, u_rready);
          chk("u_rvalid_pass", u_rvalid, rvalid);
          if (rvalid && u_rready) begin
            chk("u_rdata", u_rdata, rd);
            chk("u_rlast", u_rlast, rlast);
            if (rresp[1] || rid != 4'h0 || (rlast != (beat == int'(l)))) bad = 1;
            if (rlast || beat == int'(l)) ph = 2;
            beat++;
          end
        end
        @(negedge clk);
        n++;
      end
    end
    if (!fin) chk("rd_timeout", 0, 1);
  endtask

  task automatic run_rej(input bit wr, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    issue(wr, a, l, s);
    #1;
    exp_err = 1'b1;
    chk("rej_done_valid", done_valid, 1);
    chk("rej_done_resp", done_resp, 2'b10);
    chk("rej_done_write", done_write, wr);
    chk("rej_cmd_ready_t1", cmd_ready, 0);
    chk("rej_awvalid", awvalid, 0);
    chk("rej_arvalid", arvalid, 0);
    chk("rej_err_sticky", err_sticky, 1);
    @(negedge clk);
    #1;
    chk("rej_cmd_ready_t2", cmd_ready, 1);
    chk("rej_done_low", done_valid, 0);
    chk("rej_awvalid_t2", awvalid, 0);
    chk("rej_arvalid_t2", arvalid, 0);
    $display("reject addr=%08h len=%0d size=%0d", a, l, s);
  endtask

  initial begin
    bit          wr, legal;
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    int          bytes;

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    set_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_awvalid", awvalid, 0);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_bready", bready, 0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_err_sticky", err_sticky, 0);
    chk("reset_awaddr", awaddr, 0);
    chk("reset_awlen", awlen, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("reset_cmd_ready", cmd_ready, 1);

    run_write(32'h100, 3, 2, 0, 0, 2'b00, 0, -1);
    run_read(32'h200, 7, 2, 1, 4, 7, -1);
    run_rej(1, 32'hFF8, 3, 2);
    run_read(32'h300, 3, 2, 0, -1, 1, -1);
    run_write(32'h400, 3, 2, 10, 0, 2'b00, 0, -1);
    run_write(32'h500, 3, 2, 0, 0, 2'b00, 0, 1);
    run_write(32'h500, 3, 2, 0, 1, 2'b00, 0, -1);
    run_write(32'h600, 1, 1, 2, 1, 2'b00, 1, -1);
    run_read(32'h700, 2, 2, 0, -1, 99, -1);
    run_read(32'h800, 4, 0, 1, -1, 4, 2);
    run_rej(0, 32'h10, 0, 3);
    run_write(32'hFFC, 0, 2, 0, 0, 2'b10, 0, -1);

    for (int k = 0; k < 16; k++) begin
      wr = 1'($urandom);
      s  = 3'($urandom_range(3));
      l  = 8'($urandom_range(15));
      a  = $urandom;
      if ($urandom_range(2) == 0)
        a[11:0] = 12'(4096 - ((int'(l) + 1) << (s > 2 ? 2 : s)) + $urandom_range(1));
      bytes = (int'(l) + 1) * (1 << s);
      legal = ((1 << s) <= AXI_DW / 8) && (int'(a[11:0]) + bytes <= 4096);
      if (!legal)
        run_rej(wr, a, l, s);
      else if (wr)
        run_write(a, l, s, $urandom_range(3), 1, 2'($urandom), 0, -1);
      else
        run_read(a, l, s, 1'($urandom), $urandom_range(int'(l) + 3), int'(l), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
